// File: rtl/rf_port_arbiter.sv
// rf_port_arbiter
// Shares the single-op-per-cycle register file between the decode operand
// read port and a FIFO-buffered writeback port. Reads are stalled on RAW
// hazards against queued writebacks. Write starvation is bounded by a read
// burst counter.
//
// state  | meaning
// S_IDLE | no register file op driven this cycle
// S_RD   | dual read driven (rf_addr1/rf_addr2 = operand A/B)
// S_WR   | write of the FIFO head driven (rf_addr1/rf_din, rf_wr=1)
module rf_port_arbiter #(
    parameter int WB_DEPTH     = 4,
    parameter int RD_BURST_MAX = 4,
    parameter int ADDR_W       = 5,
    parameter int DATA_W       = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rd_req,
    input  logic [ADDR_W-1:0]         rd_addr_a,
    input  logic [ADDR_W-1:0]         rd_addr_b,
    output logic                      rd_ack,
    output logic                      rd_valid,
    output logic [DATA_W-1:0]         rd_data_a,
    output logic [DATA_W-1:0]         rd_data_b,
    input  logic                      wb_req,
    input  logic [ADDR_W-1:0]         wb_addr,
    input  logic [DATA_W-1:0]         wb_data,
    output logic                      wb_ready,
    output logic [$clog2(WB_DEPTH):0] wb_count,
    output logic [ADDR_W-1:0]         rf_addr1,
    output logic [ADDR_W-1:0]         rf_addr2,
    output logic [DATA_W-1:0]         rf_din,
    output logic                      rf_wr,
    input  logic [DATA_W-1:0]         rf_out_1,
    input  logic [DATA_W-1:0]         rf_out_2
);

    localparam int PTR_W   = $clog2(WB_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int BURST_W = $clog2(RD_BURST_MAX + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RD   = 2'd1;
    localparam logic [1:0] S_WR   = 2'd2;

    logic [ADDR_W-1:0]  fifo_addr [WB_DEPTH];
    logic [DATA_W-1:0]  fifo_data [WB_DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [BURST_W-1:0] burst;
    logic [1:0]         state;
    logic [1:0]         next_state;

    logic full;
    logic push;
    logic hazard;
    logic w_cand;
    logic r_cand;
    logic grant_rd;
    logic grant_wr;

    assign full     = (wb_count == CNT_W'(WB_DEPTH));
    assign wb_ready = !full;
    assign push     = wb_req && wb_ready;
    assign w_cand   = (wb_count != '0);
    assign r_cand   = rd_req && !hazard;
    assign rd_ack   = grant_rd;

    // RAW hazard: operand address matches any queued writeback. A writeback
    // being pushed this same cycle is treated as queued, since it is older
    // than the read and would otherwise be overtaken by it.
    always_comb begin
        hazard = push && ((wb_addr == rd_addr_a) || (wb_addr == rd_addr_b));
        for (int i = 0; i < WB_DEPTH; i++) begin
            if (CNT_W'(i) < wb_count) begin
                if ((fifo_addr[head + PTR_W'(i)] == rd_addr_a) ||
                    (fifo_addr[head + PTR_W'(i)] == rd_addr_b)) begin
                    hazard = 1'b1;
                end
            end
        end
    end

    // Grant selection: writes win when the FIFO is full or reads have used
    // up their burst allowance; otherwise a ready read goes first.
    always_comb begin
        grant_rd = 1'b0;
        grant_wr = 1'b0;
        if (r_cand && w_cand) begin
            if (full || (burst == BURST_W'(RD_BURST_MAX))) begin
                grant_wr = 1'b1;
            end else begin
                grant_rd = 1'b1;
            end
        end else begin
            grant_rd = r_cand;
            grant_wr = w_cand;
        end
    end

    // Next op to drive onto the register file.
    always_comb begin
        if (grant_wr) begin
            next_state = S_WR;
        end else if (grant_rd) begin
            next_state = S_RD;
        end else begin
            next_state = S_IDLE;
        end
    end

    // Writeback FIFO storage; contents need no reset, validity comes from the count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[tail] <= wb_addr;
            fifo_data[tail] <= wb_data;
        end
    end

    // FIFO pointers and occupancy; a pop is exactly a write grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head     <= '0;
            tail     <= '0;
            wb_count <= '0;
        end else begin
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            if (grant_wr) begin
                head <= head + PTR_W'(1);
            end
            case ({push, grant_wr})
                2'b10:   wb_count <= wb_count + CNT_W'(1);
                2'b01:   wb_count <= wb_count - CNT_W'(1);
                default: wb_count <= wb_count;
            endcase
        end
    end

    // Consecutive reads granted while a write waits; saturates at the limit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            burst <= '0;
        end else if (grant_wr) begin
            burst <= '0;
        end else if (grant_rd && w_cand && (burst != BURST_W'(RD_BURST_MAX))) begin
            burst <= burst + BURST_W'(1);
        end
    end

    // FSM and registered register-file controls for the op decided this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            rf_wr    <= 1'b0;
            rf_addr1 <= '0;
            rf_addr2 <= '0;
            rf_din   <= '0;
        end else begin
            state <= next_state;
            case (next_state)
                S_RD: begin
                    rf_addr1 <= rd_addr_a;
                    rf_addr2 <= rd_addr_b;
                    rf_wr    <= 1'b0;
                end
                S_WR: begin
                    rf_addr1 <= fifo_addr[head];
                    rf_din   <= fifo_data[head];
                    rf_wr    <= 1'b1;
                end
                default: begin
                    rf_wr <= 1'b0;
                end
            endcase
        end
    end

    // Capture read results at the end of the S_RD cycle (reg_file read at the negedge inside it).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid  <= 1'b0;
            rd_data_a <= '0;
            rd_data_b <= '0;
        end else begin
            rd_valid <= (state == S_RD);
            if (state == S_RD) begin
                rd_data_a <= rf_out_1;
                rd_data_b <= rf_out_2;
            end
        end
    end

endmodule

// File: tb/tb_rf_port_arbiter.sv
// Testbench for rf_port_arbiter: negedge register file model, queue-based
// reference model of the arbiter, directed scenarios plus random traffic.
module tb_rf_port_arbiter;

    localparam int DEPTH = 4;
    localparam int BMAX  = 4;

    logic        clk;
    logic        rst;
    logic        rd_req;
    logic [4:0]  rd_addr_a;
    logic [4:0]  rd_addr_b;
    logic        rd_ack;
    logic        rd_valid;
    logic [15:0] rd_data_a;
    logic [15:0] rd_data_b;
    logic        wb_req;
    logic [4:0]  wb_addr;
    logic [15:0] wb_data;
    logic        wb_ready;
    logic [2:0]  wb_count;
    logic [4:0]  rf_addr1;
    logic [4:0]  rf_addr2;
    logic [15:0] rf_din;
    logic        rf_wr;
    logic [15:0] rf_out_1;
    logic [15:0] rf_out_2;

    int n_checks = 0;
    int n_fail   = 0;

    rf_port_arbiter #(
        .WB_DEPTH(DEPTH), .RD_BURST_MAX(BMAX), .ADDR_W(5), .DATA_W(16)
    ) dut (
        .clk(clk), .rst(rst),
        .rd_req(rd_req), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
        .rd_ack(rd_ack), .rd_valid(rd_valid), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .wb_req(wb_req), .wb_addr(wb_addr), .wb_data(wb_data),
        .wb_ready(wb_ready), .wb_count(wb_count),
        .rf_addr1(rf_addr1), .rf_addr2(rf_addr2), .rf_din(rf_din), .rf_wr(rf_wr),
        .rf_out_1(rf_out_1), .rf_out_2(rf_out_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] init_val(input logic [4:0] i);
        if (i == 5'd8) return 16'hAF0A;
        return {3'b101, i, ~i, 3'b011};
    endfunction

    // Register file: one op per cycle on the negedge, outputs registered.
    logic [15:0] rf_mem [32];
    logic        load_req;
    always @(negedge clk) begin
        if (load_req) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= init_val(5'(i));
        end else if (rf_wr) begin
            rf_mem[rf_addr1] <= rf_din;
        end
        rf_out_1 <= rf_mem[rf_addr1];
        rf_out_2 <= rf_mem[rf_addr2];
    end

    // Reference model: queue of pending writebacks, architectural registers,
    // burst allowance, and the expected outputs of the coming cycles.
    typedef struct packed { logic [4:0] addr; logic [15:0] data; } wb_t;
    wb_t         q[$];
    logic [15:0] m_regs [32];
    int          burst;
    bit          g_rd, g_wr, e_ready;
    bit          p_rd;
    logic [15:0] p_a, p_b;
    bit          e_valid;
    logic [15:0] e_a, e_b;
    bit          e_wr;
    logic [4:0]  e_waddr;
    logic [15:0] e_wdata;

    function automatic void model_reset();
        q.delete();
        burst = 0; p_rd = 0; p_a = 0; p_b = 0;
        e_valid = 0; e_a = 0; e_b = 0; e_wr = 0; e_waddr = 0; e_wdata = 0;
        for (int i = 0; i < 32; i++) m_regs[i] = init_val(5'(i));
    endfunction

    function automatic void model_eval();
        bit full, haz, r, w;
        full = (q.size() == DEPTH);
        w    = (q.size() != 0);
        haz  = 0;
        foreach (q[i]) if (q[i].addr == rd_addr_a || q[i].addr == rd_addr_b) haz = 1;
        if (wb_req && !full && (wb_addr == rd_addr_a || wb_addr == rd_addr_b)) haz = 1;
        r       = rd_req && !haz;
        e_ready = !full;
        g_wr    = w && (!r || full || burst >= BMAX);
        g_rd    = r && !g_wr;
    endfunction

    function automatic void model_tick();
        wb_t ent;
        bit  do_push;
        bit  had_w;
        do_push = wb_req && (q.size() < DEPTH);
        had_w   = (q.size() != 0);
        e_valid = p_rd;
        if (p_rd) begin e_a = p_a; e_b = p_b; end
        p_rd = g_rd;
        if (g_rd) begin
            p_a = m_regs[rd_addr_a];
            p_b = m_regs[rd_addr_b];
            if (had_w && burst < BMAX) burst++;
        end
        e_wr = g_wr;
        if (g_wr) begin
            ent = q.pop_front();
            m_regs[ent.addr] = ent.data;
            e_waddr = ent.addr;
            e_wdata = ent.data;
            burst = 0;
        end
        if (do_push) begin
            ent.addr = wb_addr;
            ent.data = wb_data;
            q.push_back(ent);
        end
    endfunction

    task automatic settle();
        #1;
        model_eval();
    endtask

    task automatic cycle();
        model_eval();
        @(posedge clk);
        model_tick();
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; rd_req = 1'b0; wb_req = 1'b0; load_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        load_req = 1'b0;
        #1 rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        settle();
        n_checks++; if (rd_ack !== 1'b0) begin n_fail++; $display("FAIL reset_rd_ack: got %b want 0", rd_ack); end
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
        n_checks++; if (wb_count !== 3'd0) begin n_fail++; $display("FAIL reset_wb_count: got %0d want 0", wb_count); end
        n_checks++; if (wb_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wb_ready: got %b want 1", wb_ready); end
        n_checks++; if ({rf_wr, rf_addr1, rf_addr2, rf_din} !== 27'd0) begin n_fail++;
            $display("FAIL reset_rf: got wr=%b a1=%0d a2=%0d din=%h want all 0", rf_wr, rf_addr1, rf_addr2, rf_din); end
        n_checks++; if ({rd_data_a, rd_data_b} !== 32'd0) begin n_fail++;
            $display("FAIL reset_rd_data: got %h/%h want 0/0", rd_data_a, rd_data_b); end
        // read and write in flight together, then reset mid-cycle
        rd_req = 1; rd_addr_a = 1; rd_addr_b = 2; wb_req = 1; wb_addr = 12; wb_data = 16'h1212;
        cycle();
        rd_req = 0; wb_addr = 13; wb_data = 16'h1313;
        cycle();
        wb_req = 0;
        settle();
        n_checks++; if ({rf_wr, rd_valid, wb_count} !== 5'b11_001) begin n_fail++;
            $display("FAIL reset_pre: got wr=%b valid=%b count=%0d want 1/1/1", rf_wr, rd_valid, wb_count); end
        rst = 1'b1;
        #1;
        n_checks++; if ({rf_wr, rd_valid, wb_count} !== 5'd0) begin n_fail++;
            $display("FAIL reset_mid_op: got wr=%b valid=%b count=%0d want 0/0/0", rf_wr, rd_valid, wb_count); end
        n_checks++; if (wb_ready !== 1'b1) begin n_fail++; $display("FAIL reset_mid_ready: got %b want 1", wb_ready); end
    endtask

    task automatic test_write_read();
        apply_reset();
        rd_req = 0; wb_req = 1; wb_addr = 3; wb_data = 16'h50F5;
        settle();
        n_checks++; if (wb_ready !== 1'b1) begin n_fail++; $display("FAIL wr_ready: got %b want 1", wb_ready); end
        cycle();
        wb_req = 0;
        settle();
        n_checks++; if ({wb_count, rf_wr} !== 4'b001_0) begin n_fail++;
            $display("FAIL wr_queued: got count=%0d wr=%b want 1/0", wb_count, rf_wr); end
        cycle();
        settle();
        n_checks++; if ({rf_wr, rf_addr1, rf_din, wb_count} !== {1'b1, 5'd3, 16'h50F5, 3'd0}) begin n_fail++;
            $display("FAIL wr_drive: got wr=%b a1=%0d din=%h count=%0d want 1/3/50f5/0", rf_wr, rf_addr1, rf_din, wb_count); end
        cycle();
        rd_req = 1; rd_addr_a = 3; rd_addr_b = 8;
        settle();
        n_checks++; if ({rf_wr, rd_ack} !== 2'b01) begin n_fail++;
            $display("FAIL rd_grant: got wr=%b ack=%b want 0/1", rf_wr, rd_ack); end
        cycle();
        rd_req = 0;
        settle();
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL rd_latency1: got valid=%b want 0", rd_valid); end
        cycle();
        settle();
        n_checks++; if ({rd_valid, rd_data_a, rd_data_b} !== {1'b1, 16'h50F5, 16'hAF0A}) begin n_fail++;
            $display("FAIL rd_data: got valid=%b a=%h b=%h want 1/50f5/af0a", rd_valid, rd_data_a, rd_data_b); end
        cycle();
        settle();
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL rd_pulse: got valid=%b want 0", rd_valid); end
    endtask

    task automatic test_raw();
        int got;
        apply_reset();
        wb_req = 1; wb_addr = 5; wb_data = 16'h1234;
        rd_req = 1; rd_addr_a = 5; rd_addr_b = 9;
        settle();
        n_checks++; if (rd_ack !== 1'b0) begin n_fail++; $display("FAIL raw_same_cycle: got ack=%b want 0", rd_ack); end
        cycle();
        wb_req = 0;
        got = -1;
        for (int k = 0; k < 10 && got < 0; k++) begin
            settle();
            if (rd_ack === 1'b1) got = k;
            cycle();
        end
        n_checks++; if (got != 1) begin n_fail++; $display("FAIL raw_ack_cycle: got %0d want 1 (-1 = never)", got); end
        rd_req = 0;
        settle();
        cycle();
        settle();
        n_checks++; if ({rd_valid, rd_data_a, rd_data_b} !== {1'b1, 16'h1234, init_val(5'd9)}) begin n_fail++;
            $display("FAIL raw_data: got valid=%b a=%h b=%h want 1/1234/%h", rd_valid, rd_data_a, rd_data_b, init_val(5'd9)); end
    endtask

    task automatic test_full();
        apply_reset();
        rd_req = 1; rd_addr_a = 9; rd_addr_b = 10;
        for (int k = 0; k < 4; k++) begin
            wb_req = 1; wb_addr = 5'(k + 1); wb_data = 16'($urandom);
            settle();
            n_checks++; if ({rd_ack, wb_ready, wb_count} !== {2'b11, 3'(k)}) begin n_fail++;
                $display("FAIL full_fill%0d: got ack=%b ready=%b count=%0d want 1/1/%0d", k, rd_ack, wb_ready, wb_count, k); end
            cycle();
        end
        wb_addr = 11; wb_data = 16'hDEAD;
        settle();
        n_checks++; if ({wb_count, wb_ready, rd_ack} !== 5'b100_00) begin n_fail++;
            $display("FAIL full_block: got count=%0d ready=%b ack=%b want 4/0/0", wb_count, wb_ready, rd_ack); end
        cycle();
        wb_req = 0;
        settle();
        n_checks++; if ({wb_count, rf_wr, rf_addr1} !== {3'd3, 1'b1, 5'd1}) begin n_fail++;
            $display("FAIL full_pop: got count=%0d wr=%b a1=%0d want 3/1/1", wb_count, rf_wr, rf_addr1); end
        for (int k = 0; k < 40 && q.size() != 0; k++) begin
            settle();
            n_checks++; if (rd_ack !== g_rd) begin n_fail++; $display("FAIL full_drain_ack: got %b want %b", rd_ack, g_rd); end
            n_checks++; if (wb_count !== 3'(q.size())) begin n_fail++;
                $display("FAIL full_drain_count: got %0d want %0d", wb_count, q.size()); end
            cycle();
        end
        settle();
        n_checks++; if ({rd_ack, wb_count} !== 4'b1_000) begin n_fail++;
            $display("FAIL full_drained: got ack=%b count=%0d want 1/0", rd_ack, wb_count); end
        cycle();
        rd_req = 0;
        for (int k = 0; k < 3; k++) begin
            settle();
            n_checks++; if (rd_valid !== e_valid || (e_valid && {rd_data_a, rd_data_b} !== {e_a, e_b})) begin n_fail++;
                $display("FAIL full_flush: got %b %h/%h want %b %h/%h", rd_valid, rd_data_a, rd_data_b, e_valid, e_a, e_b); end
            cycle();
        end
    endtask

    task automatic test_starvation();
        int run;
        apply_reset();
        rd_req = 1; rd_addr_a = 1; rd_addr_b = 2;
        wb_req = 1; wb_addr = 20; wb_data = 16'hC3C3;
        settle();
        n_checks++; if (rd_ack !== 1'b1) begin n_fail++; $display("FAIL starve_first: got ack=%b want 1", rd_ack); end
        cycle();
        wb_req = 0;
        run = 0;
        for (int k = 0; k < 8; k++) begin
            settle();
            if (rd_ack !== 1'b1) break;
            run++;
            cycle();
        end
        n_checks++; if (run != BMAX) begin n_fail++; $display("FAIL starve_burst: got %0d reads want %0d", run, BMAX); end
        n_checks++; if (wb_count !== 3'd1) begin n_fail++; $display("FAIL starve_count: got %0d want 1", wb_count); end
        cycle();
        settle();
        n_checks++; if ({rf_wr, rf_addr1, rf_din, rd_ack} !== {1'b1, 5'd20, 16'hC3C3, 1'b1}) begin n_fail++;
            $display("FAIL starve_write: got wr=%b a1=%0d din=%h ack=%b want 1/20/c3c3/1", rf_wr, rf_addr1, rf_din, rd_ack); end
        cycle();
        rd_req = 0;
        cycle();
        cycle();
    endtask

    task automatic test_order();
        apply_reset();
        rd_req = 0; wb_req = 1; wb_addr = 7; wb_data = 16'h0001;
        settle();
        cycle();
        wb_data = 16'h0002;
        settle();
        n_checks++; if (wb_count !== 3'd1) begin n_fail++; $display("FAIL order_count: got %0d want 1", wb_count); end
        cycle();
        wb_req = 0;
        settle();
        n_checks++; if ({rf_wr, rf_din, wb_count} !== {1'b1, 16'h0001, 3'd1}) begin n_fail++;
            $display("FAIL order_first: got wr=%b din=%h count=%0d want 1/0001/1", rf_wr, rf_din, wb_count); end
        cycle();
        rd_req = 1; rd_addr_a = 7; rd_addr_b = 7;
        settle();
        n_checks++; if ({rf_wr, rf_din, wb_count, rd_ack} !== {1'b1, 16'h0002, 3'd0, 1'b1}) begin n_fail++;
            $display("FAIL order_second: got wr=%b din=%h count=%0d ack=%b want 1/0002/0/1", rf_wr, rf_din, wb_count, rd_ack); end
        cycle();
        rd_req = 0;
        settle();
        cycle();
        settle();
        n_checks++; if ({rd_valid, rd_data_a, rd_data_b} !== {1'b1, 16'h0002, 16'h0002}) begin n_fail++;
            $display("FAIL order_read: got valid=%b a=%h b=%h want 1/0002/0002", rd_valid, rd_data_a, rd_data_b); end
    endtask

    task automatic test_random();
        bit acked;
        apply_reset();
        for (int k = 0; k < 3000; k++) begin
            if (!rd_req) begin
                rd_req    = ($urandom_range(0, 99) < 60);
                rd_addr_a = 5'($urandom_range(0, 7));
                rd_addr_b = 5'($urandom_range(0, 7));
            end
            wb_req  = ($urandom_range(0, 99) < 40);
            wb_addr = 5'($urandom_range(0, 7));
            wb_data = 16'($urandom);
            settle();
            n_checks++; if (rd_ack !== g_rd) begin n_fail++; $display("FAIL rnd_ack @%0d: got %b want %b", k, rd_ack, g_rd); end
            n_checks++; if (wb_ready !== e_ready) begin n_fail++; $display("FAIL rnd_ready @%0d: got %b want %b", k, wb_ready, e_ready); end
            n_checks++; if (wb_count !== 3'(q.size())) begin n_fail++; $display("FAIL rnd_count @%0d: got %0d want %0d", k, wb_count, q.size()); end
            n_checks++; if (rd_valid !== e_valid) begin n_fail++; $display("FAIL rnd_valid @%0d: got %b want %b", k, rd_valid, e_valid); end
            if (e_valid) begin
                n_checks++; if ({rd_data_a, rd_data_b} !== {e_a, e_b}) begin n_fail++;
                    $display("FAIL rnd_data @%0d: got %h/%h want %h/%h", k, rd_data_a, rd_data_b, e_a, e_b); end
            end
            n_checks++; if (rf_wr !== e_wr) begin n_fail++; $display("FAIL rnd_rf_wr @%0d: got %b want %b", k, rf_wr, e_wr); end
            if (e_wr) begin
                n_checks++; if ({rf_addr1, rf_din} !== {e_waddr, e_wdata}) begin n_fail++;
                    $display("FAIL rnd_wr_op @%0d: got %0d/%h want %0d/%h", k, rf_addr1, rf_din, e_waddr, e_wdata); end
            end
            acked = g_rd;
            cycle();
            if (acked) rd_req = 0;
        end
        rd_req = 0;
        wb_req = 0;
    endtask

    initial begin
        rst = 1'b0; rd_req = 0; rd_addr_a = 0; rd_addr_b = 0;
        wb_req = 0; wb_addr = 0; wb_data = 0; load_req = 0;
        model_reset();
        #1 rst = 1'b1;
        test_reset();
        test_write_read();
        test_raw();
        test_full();
        test_starvation();
        test_order();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
